// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the iterative divider.
//   div_state_e : FSM states (IDLE, CALC, DONE)
//   div_req_t   : operation request (signedness, dividend, divisor), sized for up to DIV_MAX_W bits
//   DIV_DZ_QUOT : quotient returned on a zero divisor (all ones, sliced to WIDTH by users)
package div_pkg;
    localparam int DIV_MAX_W = 64;
    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_e;
    typedef struct packed {
        logic                 is_signed;
        logic [DIV_MAX_W-1:0] dividend;
        logic [DIV_MAX_W-1:0] divisor;
    } div_req_t;
    localparam logic [DIV_MAX_W-1:0] DIV_DZ_QUOT = '1;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring iteration on magnitudes.
//   rem/quo      : current partial remainder and {remaining dividend bits, quotient bits}
//   dvs          : divisor magnitude
//   rem_next/quo_next : state after shifting in the next dividend bit and trying a subtract
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);
    logic [WIDTH:0] trial, diff;
    assign trial    = {rem, quo[WIDTH-1]};
    assign diff     = trial - {1'b0, dvs};
    // A clear borrow bit means the trial subtraction fits: keep it and emit a 1.
    assign rem_next = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], ~diff[WIDTH]};
endmodule

// File: rtl/div_iter_unit.sv
// div_iter_unit: fixed-latency signed/unsigned restoring divider with flush.
//   clk, reset (sync, active-high), flush (cancels any operation)
//   in_valid/in_ready, in_signed, dividend, divisor : operation request handshake
//   out_valid/out_ready, quotient, remainder, div_by_zero : result handshake
//   busy : unit is not idle
module div_iter_unit
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);
    div_state_e       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem, quo, dvs, raw_dvd, rem_next, quo_next;
    logic             q_neg, r_neg, dz, accept, last;

    assign in_ready = !flush && (state == IDLE || (state == DONE && out_ready));
    assign accept   = in_valid && in_ready;
    assign last     = cnt == CNT_W'(WIDTH - 1);

    // Accept is only possible from IDLE or DONE, so its priority over the
    // CALC/DONE transitions below never masks them.
    always_comb begin
        state_next = state;
        if (flush)
            state_next = IDLE;
        else if (accept)
            state_next = CALC;
        else if (state == CALC && last)
            state_next = DONE;
        else if (state == DONE && out_ready)
            state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem),
        .quo     (quo),
        .dvs     (dvs),
        .rem_next(rem_next),
        .quo_next(quo_next)
    );

    // quo starts as the dividend magnitude and is shifted out MSB-first while
    // quotient bits shift in, so after WIDTH steps it holds the quotient.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            raw_dvd <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            dz      <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            rem     <= '0;
            quo     <= (in_signed && dividend[WIDTH-1]) ? -dividend : dividend;
            dvs     <= (in_signed && divisor[WIDTH-1]) ? -divisor : divisor;
            raw_dvd <= dividend;
            q_neg   <= in_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg   <= in_signed && dividend[WIDTH-1];
            dz      <= divisor == '0;
        end else if (state == CALC) begin
            cnt     <= cnt + 1'b1;
            rem     <= rem_next;
            quo     <= quo_next;
        end
    end

    assign quotient    = dz ? DIV_DZ_QUOT[WIDTH-1:0] : (q_neg ? -quo : quo);
    assign remainder   = dz ? raw_dvd : (r_neg ? -rem : rem);
    assign div_by_zero = dz;
    assign out_valid   = state == DONE;
    assign busy        = state != IDLE;
endmodule

// File: tb/tb_div_iter_unit.sv
// tb_div_iter_unit: directed and randomized checks of 32-bit and 8-bit divider instances.
module tb_div_iter_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        fl32, v32, rdy32, s32, ov32, or32, dz32, bz32;
    logic [31:0] a32, b32, q32, r32;
    logic        fl8, v8, rdy8, s8, ov8, or8, dz8, bz8;
    logic [7:0]  a8, b8, q8, r8;
    int n_chk = 0;
    int n_fail = 0;

    div_iter_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .flush(fl32), .in_valid(v32), .in_ready(rdy32),
        .in_signed(s32), .dividend(a32), .divisor(b32), .out_valid(ov32),
        .out_ready(or32), .quotient(q32), .remainder(r32), .div_by_zero(dz32), .busy(bz32)
    );

    div_iter_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .flush(fl8), .in_valid(v8), .in_ready(rdy8),
        .in_signed(s8), .dividend(a8), .divisor(b8), .out_valid(ov8),
        .out_ready(or8), .quotient(q8), .remainder(r8), .div_by_zero(dz8), .busy(bz8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic go32(input logic s, input logic [31:0] a, input logic [31:0] b);
        s32 = s; a32 = a; b32 = b; v32 = 1'b1;
        @(negedge clk);
        v32 = 1'b0;
    endtask

    task automatic wait32(input string tag);
        int n = 0;
        while (!ov32 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'd32);
    endtask

    task automatic run32(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz);
        go32(s, a, b);
        check({tag, "_rdy"}, 64'(rdy32), 64'd0);
        check({tag, "_busy"}, 64'(bz32), 64'd1);
        wait32(tag);
        check({tag, "_q"}, 64'(q32), 64'(eq));
        check({tag, "_r"}, 64'(r32), 64'(er));
        check({tag, "_dz"}, 64'(dz32), 64'(edz));
        @(negedge clk);
        check({tag, "_ovdrop"}, 64'(ov32), 64'd0);
    endtask

    task automatic go8(input logic s, input logic [7:0] a, input logic [7:0] b);
        s8 = s; a8 = a; b8 = b; v8 = 1'b1;
        @(negedge clk);
        v8 = 1'b0;
    endtask

    task automatic wait8(input string tag);
        int n = 0;
        while (!ov8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'd8);
    endtask

    task automatic model8(input logic s, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] q, output logic [7:0] r);
        logic signed [7:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 8'h00) begin
            q = 8'hFF; r = a;
        end else if (!s) begin
            q = a / b; r = a % b;
        end else if (a == 8'h80 && b == 8'hFF) begin
            q = 8'h80; r = 8'h00;
        end else begin
            q = sa / sb; r = sa % sb;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic seen;
        reset = 1'b1;
        fl32 = 0; v32 = 0; s32 = 0; a32 = 0; b32 = 0; or32 = 1;
        fl8 = 0; v8 = 0; s8 = 0; a8 = 0; b8 = 0; or8 = 1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 64'(bz32), 64'd0);
        check("rst_ov", 64'(ov32), 64'd0);
        check("rst_dz", 64'(dz32), 64'd0);
        check("rst_q", 64'(q32), 64'd0);
        check("rst_r", 64'(r32), 64'd0);
        check("rst_rdy", 64'(rdy32), 64'd1);
        check("rst_rdy8", 64'(rdy8), 64'd1);

        run32("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        run32("sm7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        run32("s7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0);
        run32("sovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);
        run32("dz", 1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1);
        run32("u_big", 1'b0, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 1'b0);

        go32(1'b0, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        fl32 = 1'b1;
        check("fl_rdy", 64'(rdy32), 64'd0);
        @(negedge clk);
        fl32 = 1'b0;
        check("fl_busy", 64'(bz32), 64'd0);
        check("fl_ov", 64'(ov32), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ov32) seen = 1'b1;
        end
        check("fl_never", 64'(seen), 64'd0);
        run32("after_fl", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        or32 = 1'b0;
        go32(1'b0, 32'd50, 32'd5);
        wait32("stall");
        repeat (5) begin
            @(negedge clk);
            check("stall_ov", 64'(ov32), 64'd1);
            check("stall_q", 64'(q32), 64'd10);
            check("stall_r", 64'(r32), 64'd0);
        end
        s32 = 1'b0; a32 = 32'd20; b32 = 32'd6; v32 = 1'b1; or32 = 1'b1;
        @(negedge clk);
        v32 = 1'b0;
        check("b2b_busy", 64'(bz32), 64'd1);
        check("b2b_ov", 64'(ov32), 64'd0);
        wait32("b2b");
        check("b2b_q", 64'(q32), 64'd3);
        check("b2b_r", 64'(r32), 64'd2);
        @(negedge clk);

        go32(1'b0, 32'd77, 32'd7);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst_busy", 64'(bz32), 64'd0);
        check("mrst_ov", 64'(ov32), 64'd0);
        check("mrst_q", 64'(q32), 64'd0);

        go8(1'b0, 8'd255, 8'd16);
        wait8("w8");
        check("w8_q", 64'(q8), 64'd15);
        check("w8_r", 64'(r8), 64'd15);
        @(negedge clk);
        go8(1'b1, 8'h80, 8'hFF);
        wait8("w8ovf");
        check("w8ovf_q", 64'(q8), 64'h80);
        check("w8ovf_r", 64'(r8), 64'h00);
        @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            logic [7:0] a, b, eq, er;
            logic s, fl;
            int stall;
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            s = 1'($urandom);
            fl = $urandom_range(0, 7) == 0;
            stall = $urandom_range(0, 3);
            model8(s, a, b, eq, er);
            or8 = (stall == 0);
            go8(s, a, b);
            if (fl) begin
                repeat ($urandom_range(0, 5)) @(negedge clk);
                fl8 = 1'b1;
                @(negedge clk);
                fl8 = 1'b0;
                or8 = 1'b1;
                check("rnd_fl_ov", 64'(ov8), 64'd0);
                check("rnd_fl_busy", 64'(bz8), 64'd0);
            end else begin
                wait8("rnd");
                check("rnd_q", 64'(q8), 64'(eq));
                check("rnd_r", 64'(r8), 64'(er));
                check("rnd_dz", 64'(dz8), 64'(b == 8'h00));
                repeat (stall) begin
                    @(negedge clk);
                    check("rnd_hold_ov", 64'(ov8), 64'd1);
                    check("rnd_hold_q", 64'(q8), 64'(eq));
                end
                or8 = 1'b1;
                @(negedge clk);
                check("rnd_ovdrop", 64'(ov8), 64'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
